// File: rtl/mux7_frame_rx.sv
// Receiver for the 7-slot mux7sel frame: idle=1, start=0, 5 payload slots LSB-first, stop=1.
// Latency: rx_valid/frame_err pulse 1 cycle after the stop-slot mid sample (+2 with MUX7_RX_SYNC_EN).
// Backpressure: none; a stop slot sampled low parks in RECOVER until the line returns high.
module mux7_frame_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic serin,
    output logic thrsh,
    output logic regh_b0,
    output logic regl_b0,
    output logic regh_b2,
    output logic regl_b2,
    output logic rx_valid,
    output logic frame_err,
    output logic busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [4:0]      shift_q, shift_d;
    logic [4:0]      pay_q, pay_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            line;

`ifdef MUX7_RX_SYNC_EN
    logic [1:0] sync_q;

    // Resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serin};
        end
    end

    assign line = sync_q[1];
`else
    assign line = serin;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            pay_q       <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pay_q       <= pay_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pay_d       = pay_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!line) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                // A start bit still high at mid-slot was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[4:1]};
                    if (bit_q == 3'd4) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (line) begin
                        pay_d      = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign thrsh     = pay_q[0];
    assign regh_b0   = pay_q[1];
    assign regl_b0   = pay_q[2];
    assign regh_b2   = pay_q[3];
    assign regl_b2   = pay_q[4];
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux7_frame_rx.sv
// Bench for mux7_frame_rx: directed scenarios plus random frames, scoreboard of expected pulses.
module tb_mux7_frame_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
`ifdef MUX7_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Start-bit low seen on the edge after it is driven; stop slot is sampled HALF+6 slots later.
    localparam int RX_LAT = 1 + HALF + 6 * CPB + SYNC_LAT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serin = 1'b1;
    logic thrsh, regh_b0, regl_b0, regh_b2, regl_b2, rx_valid, frame_err, busy;

    mux7_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .serin     (serin),
        .thrsh     (thrsh),
        .regh_b0   (regh_b0),
        .regl_b0   (regl_b0),
        .regh_b2   (regh_b2),
        .regl_b2   (regl_b2),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         err;
        logic [4:0] p;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] exp_out = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [4:0] outs();
        return {regl_b2, regh_b2, regl_b0, regh_b0, thrsh};
    endfunction

    // Monitor: every pulse must match the oldest expected frame outcome, in kind and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_out = '0;
        end else begin
            check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (rx_valid || frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {31'd0, rx_valid | frame_err}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                    check("pulse_cycle", cyc, e.cyc);
                    if (!e.err) exp_out = e.p;
                end
            end
            check("payload", {27'd0, outs()}, {27'd0, exp_out});
        end
    end

    task automatic slot(input logic b);
        serin = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // p[0] is thrsh (first on the wire) ... p[4] is regl_b2.
    task automatic send_frame(input logic [4:0] p, input logic stop_b);
        exp_t e;
        e.err = !stop_b;
        e.p   = p;
        e.cyc = cyc + RX_LAT;
        sb.push_back(e);
        slot(1'b0);
        for (int i = 0; i < 5; i++) slot(p[i]);
        slot(stop_b);
    endtask

    task automatic glitch(input int len);
        serin = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        serin = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] p;
        int         r;

        #2;
        check("reset_payload", {27'd0, outs()}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        send_frame(5'b01101, 1'b1);
        idle(4);

        glitch(2);
        idle(3);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        send_frame(5'b11111, 1'b1);
        idle(2);
        send_frame(5'b00110, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("recover_busy", {31'd0, busy}, 32'd1);
        end
        serin = 1'b1;
        repeat (1 + SYNC_LAT) @(posedge clk);
        #1;
        check("recover_exit_busy", {31'd0, busy}, 32'd0);
        idle(2);

        send_frame(5'b01010, 1'b1);
        send_frame(5'b10101, 1'b1);
        idle(3);

        slot(1'b0);
        slot(1'b1);
        slot(1'b0);
        reset = 1'b1;
        #1;
        check("midreset_payload", {27'd0, outs()}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        send_frame(5'b10011, 1'b1);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            p = 5'($urandom);
            if (r == 0) begin
                glitch($urandom_range(1, HALF));
                idle($urandom_range(2, 4));
            end else if (r == 1) begin
                send_frame(p, 1'b0);
                idle($urandom_range(2, 4));
            end else begin
                send_frame(p, 1'b1);
                idle($urandom_range(0, 3));
            end
        end

        idle(2);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        @(negedge clk);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
